// File: rtl/llsc_unit_pkg.sv
// +----------------------------------------------------------------------+
// | llsc_unit_pkg                                                        |
// | Shared state encoding for the LL/SC MEM-stage resolver.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package llsc_unit_pkg;

    typedef enum logic [1:0] {
        LLSC_IDLE     = 2'd0,
        LLSC_SC_WRITE = 2'd1,
        LLSC_SC_DONE  = 2'd2
    } llsc_state_t;

endpackage

`default_nettype wire

// File: rtl/llsc_link_tracker.sv
// +----------------------------------------------------------------------+
// | llsc_link_tracker                                                    |
// | Holds the LL link (valid + word address), snoop kill, LL priority.   |
// | Optional macro: LLSC_ADDR_CHECK_EN (store and compare link address). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module llsc_link_tracker #(
    parameter int ADDR_W   = 32,
    parameter int LINK_LSB = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set,
    input  logic              i_clear,
    input  logic              i_snoop_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] i_snoop_addr,
    output logic              o_link_valid,
    output logic              o_addr_match
);

    logic r_link_valid;
    logic w_snoop_hit;

`ifdef LLSC_ADDR_CHECK_EN
    logic [ADDR_W-LINK_LSB-1:0] r_link_addr;
    logic                       w_unused_lsb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_link_addr <= '0;
        end else if (i_set) begin
            r_link_addr <= i_addr[ADDR_W-1:LINK_LSB];
        end
    end

    assign w_snoop_hit  = i_snoop_we && (i_snoop_addr[ADDR_W-1:LINK_LSB] == r_link_addr);
    assign o_addr_match = (i_addr[ADDR_W-1:LINK_LSB] == r_link_addr);
    assign w_unused_lsb = ^{i_addr[LINK_LSB-1:0], i_snoop_addr[LINK_LSB-1:0]};
`else
    logic w_unused_addr;

    // Without a stored address any foreign store is treated as hitting the link.
    assign w_snoop_hit   = i_snoop_we;
    assign o_addr_match  = 1'b1;
    assign w_unused_addr = ^{i_addr, i_snoop_addr};
`endif

    // A new LL wins over a coinciding snoop or clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_link_valid <= 1'b0;
        end else if (i_set) begin
            r_link_valid <= 1'b1;
        end else if (i_clear || w_snoop_hit) begin
            r_link_valid <= 1'b0;
        end
    end

    assign o_link_valid = r_link_valid;

endmodule

`default_nettype wire

// File: rtl/llsc_unit.sv
// +----------------------------------------------------------------------+
// | llsc_unit                                                            |
// | MEM-stage LL/SC resolver: SC decision, conditional store, stall.     |
// | Optional macro: LLSC_ADDR_CHECK_EN (address-checked link).           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module llsc_unit
    import llsc_unit_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LINK_LSB = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              is_ll,
    input  logic              is_sc,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] sc_wdata,
    input  logic              llbit_i,
    input  logic              wb_llbit_we,
    input  logic              wb_llbit_value,
    input  logic              snoop_we,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    output logic              llbit_we_o,
    output logic              llbit_value_o,
    output logic [DATA_W-1:0] sc_result_o,
    output logic              stallreq_o
);

    llsc_state_t       r_state;
    llsc_state_t       w_state_nxt;
    logic              r_flushed;
    logic              w_flushed_nxt;
    logic              r_bus_req;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;

    logic w_llbit_eff;
    logic w_link_valid;
    logic w_addr_match;
    logic w_sc_ok;
    logic w_link_set;
    logic w_link_clr;
    logic w_start;
    logic w_result;

    assign w_llbit_eff = wb_llbit_we ? wb_llbit_value : llbit_i;
    assign w_sc_ok     = w_llbit_eff && w_link_valid && w_addr_match;

    llsc_link_tracker #(
        .ADDR_W   (ADDR_W),
        .LINK_LSB (LINK_LSB)
    ) u_link_tracker (
        .clk          (clk),
        .rst          (rst),
        .i_set        (w_link_set),
        .i_clear      (w_link_clr),
        .i_snoop_we   (snoop_we),
        .i_addr       (mem_addr),
        .i_snoop_addr (snoop_addr),
        .o_link_valid (w_link_valid),
        .o_addr_match (w_addr_match)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_flushed_nxt = r_flushed;
        llbit_we_o    = 1'b0;
        llbit_value_o = 1'b0;
        w_result      = 1'b0;
        stallreq_o    = 1'b0;
        w_link_set    = 1'b0;
        w_link_clr    = 1'b0;
        w_start       = 1'b0;
        case (r_state)
            LLSC_IDLE: begin
                w_flushed_nxt = 1'b0;
                if (flush) begin
                    w_link_clr = 1'b1;
                end else if (is_sc) begin
                    if (w_sc_ok) begin
                        stallreq_o  = 1'b1;
                        w_start     = 1'b1;
                        w_state_nxt = LLSC_SC_WRITE;
                    end else begin
                        llbit_we_o = 1'b1;
                    end
                end else if (is_ll) begin
                    w_link_set    = 1'b1;
                    llbit_we_o    = 1'b1;
                    llbit_value_o = 1'b1;
                end
            end
            LLSC_SC_WRITE: begin
                // The store is already on the bus; a flush only cancels the result.
                stallreq_o = 1'b1;
                if (flush) begin
                    w_flushed_nxt = 1'b1;
                end
                if (bus_ack) begin
                    w_flushed_nxt = 1'b0;
                    w_state_nxt   = (r_flushed || flush) ? LLSC_IDLE : LLSC_SC_DONE;
                end
            end
            LLSC_SC_DONE: begin
                w_link_clr  = 1'b1;
                w_state_nxt = LLSC_IDLE;
                if (!flush) begin
                    llbit_we_o = 1'b1;
                    w_result   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = LLSC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LLSC_IDLE;
            r_flushed   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_flushed <= w_flushed_nxt;
            if (w_start) begin
                r_bus_req   <= 1'b1;
                r_bus_addr  <= mem_addr;
                r_bus_wdata <= sc_wdata;
            end else if ((r_state == LLSC_SC_WRITE) && bus_ack) begin
                r_bus_req <= 1'b0;
            end
        end
    end

    assign bus_req     = r_bus_req;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign sc_result_o = {{(DATA_W-1){1'b0}}, w_result};

endmodule

`default_nettype wire

// File: doc/llsc_unit.md
# llsc_unit

MEM-stage resolver for MIPS LL/SC, on the read side of the LLbit register. It consumes the committed LLbit and forwards a pending WB-stage LLbit write. For SC it decides success or failure, performs the conditional store over a req/ack data bus, and stalls the pipeline while that store is in flight. It produces the LLbit write request and the SC result that travel down MEM/WB into the LLbit register and the register file.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data and result width
- LINK_LSB, 2, low address bits ignored for link matching (word granularity)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (`RstEnable`)
- flush  in  1  exception flush
- is_ll  in  1  MEM-stage instruction is LL
- is_sc  in  1  MEM-stage instruction is SC
- mem_addr  in  ADDR_W  effective address
- sc_wdata  in  DATA_W  SC store data (rt)
- llbit_i  in  1  committed LLbit from the LLbit register
- wb_llbit_we  in  1  pending WB-stage LLbit write
- wb_llbit_value  in  1  pending WB-stage LLbit value
- snoop_we  in  1  store by another master
- snoop_addr  in  ADDR_W  address of that store
- bus_req  out  1  store request
- bus_addr  out  ADDR_W  store address
- bus_wdata  out  DATA_W  store data
- bus_ack  in  1  store accepted, one-cycle pulse
- llbit_we_o  out  1  LLbit write request
- llbit_value_o  out  1  LLbit write value
- sc_result_o  out  DATA_W  rt writeback value for SC (1 or 0)
- stallreq_o  out  1  pipeline stall request

## Operation
- Effective LLbit: `wb_llbit_value` when `wb_llbit_we` is high, otherwise `llbit_i`.
- SC success condition: effective LLbit AND `link_valid` AND address match.
  - Address match: `mem_addr[ADDR_W-1:LINK_LSB]` equals `link_addr`.
- FSM states: IDLE, SC_WRITE, SC_DONE.
- IDLE with `is_ll`:
  - Latch `link_addr` and set `link_valid`.
  - Drive `llbit_we_o`=1, `llbit_value_o`=1.
  - No stall.
- IDLE with `is_sc` and the condition false:
  - Drive `sc_result_o`=0, `llbit_we_o`=1, `llbit_value_o`=0.
  - No bus access, no stall; remain in IDLE.
- IDLE with `is_sc` and the condition true:
  - Assert `stallreq_o`.
  - Register `bus_addr`/`bus_wdata`, go to SC_WRITE.
- SC_WRITE:
  - Hold `bus_req`=1 with stable address and data; `stallreq_o`=1.
  - On `bus_ack` go to SC_DONE.
- SC_DONE (one cycle):
  - Drive `sc_result_o`=1, `llbit_we_o`=1, `llbit_value_o`=0.
  - Clear `link_valid`; `stallreq_o`=0; go to IDLE.
- Snoop: `snoop_we` whose address matches `link_addr` clears `link_valid`.
  - If it coincides with an LL, the LL wins and the link is set.
- `flush` in IDLE: clear `link_valid`; suppress `llbit_we_o` and `sc_result_o` for that cycle.
- `flush` in SC_WRITE: the bus store completes (no retraction). The block still waits for `bus_ack`, then returns to IDLE directly with no result and no LLbit write.
- Simultaneous `is_ll` and `is_sc` cannot occur; if both are high, SC takes priority.

## Timing
- Reset values:
  - FSM in IDLE; `link_valid`=0, `link_addr`=0.
  - All outputs 0: `bus_req`, `bus_addr`, `bus_wdata`, `llbit_we_o`, `llbit_value_o`, `sc_result_o`, `stallreq_o`.
- Reset mid-SC_WRITE: abandon the transaction immediately and go to IDLE; `bus_req` drops on the next edge.
- LL and failing SC: combinational outputs, zero added latency.
- Successful SC: `stallreq_o` is high from the decision cycle through the `bus_ack` cycle. The result appears one cycle after `bus_ack`.
  - Minimum 3 cycles with ack on the first SC_WRITE cycle.
- `bus_req` is registered and deasserts the cycle after `bus_ack`.

## Configuration
- `LLSC_ADDR_CHECK_EN` defined:
  - `link_addr` is stored and compared on SC and snoop as described.
- `LLSC_ADDR_CHECK_EN` undefined:
  - No `link_addr` register; SC success is effective LLbit AND `link_valid`.
  - Any `snoop_we` clears `link_valid` regardless of `snoop_addr`.

## Structure
- `defines.v` holds the shared constants:
  - FSM state encodings `LLSC_IDLE`, `LLSC_SC_WRITE`, `LLSC_SC_DONE`.
  - The existing `RstEnable` and `WriteEnable` macros.
- One sub-module is natural: `llsc_link_tracker`, holding `link_valid`, `link_addr`, the snoop match and the LL-over-snoop priority.

## Test plan
- LL to 0x100, then SC to 0x100 with data 0xDEADBEEF, ack after 2 cycles:
  - Bus writes 0xDEADBEEF to 0x100.
  - Stall for 3 cycles; `sc_result_o`=1; LLbit written 0.
- SC with no prior LL (`llbit_i`=0):
  - `sc_result_o`=0 in the same cycle; `bus_req` never asserted; no stall.
- LL at 0x200, then `snoop_we` at 0x200, then SC at 0x200:
  - SC fails (result 0).
  - Repeat with snoop at 0x300: success, with the macro defined.
- SC while WB forwards `wb_llbit_we`=1, `wb_llbit_value`=0 and `llbit_i`=1:
  - Fails; forwarded value takes precedence.
- `flush` during SC_WRITE, ack 1 cycle later:
  - Bus store completes.
  - Returns to IDLE; no `llbit_we_o` and no `sc_result_o` pulse.
- `rst` asserted in SC_WRITE:
  - Next cycle: IDLE, `bus_req`=0, `stallreq_o`=0, `link_valid`=0.
